inv_key_schedule: RTL and testbench



---
 rtl/inv_key_schedule.sv | 121 ++++++++++++
 tb/tb_inv_key_schedule.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key-schedule engine.
// Loaded with the round-10 key, it emits round keys 10 down to 0, one per
// valid/ready handshake. Each previous key is derived combinationally from
// the current key register with a single 4-byte SubWord.
module inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         abort,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] key_out,
  output logic [3:0]   key_round,
  output logic         busy,
  output logic         done
);

  // The schedule maths below only holds for the 10-round variant.
  generate
    if (NR != 10) begin : g_nr_check
      $error("inv_key_schedule: only NR=10 (AES-128) is supported");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EMIT, FINISH} state_t;

  // Forward AES S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant used when stepping from round r back to round r-1.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t        r_state, w_next;
  logic [127:0]  r_key;
  logic [3:0]    r_round;

  logic [31:0]   w_w0, w_w1, w_w2, w_w3;
  logic [31:0]   w_p0, w_p1, w_p2, w_p3;
  logic [31:0]   w_rot, w_sub;
  logic [127:0]  w_prev;
  logic          w_hs;
  logic          w_last;

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  // Undo the forward XOR chain, then recover w0 through the g() function.
  assign w_p3  = w_w3 ^ w_w2;
  assign w_p2  = w_w2 ^ w_w1;
  assign w_p1  = w_w1 ^ w_w0;
  assign w_rot = {w_p3[23:0], w_p3[31:24]};
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
  assign w_p0  = w_w0 ^ w_sub ^ {rcon(r_round), 24'h0};
  assign w_prev = {w_p0, w_p1, w_p2, w_p3};

  // Abort takes precedence: a handshake in an abort cycle is dropped.
  assign w_hs   = (r_state == EMIT) && key_ready && !abort;
  assign w_last = (r_round == 4'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = EMIT;
      EMIT: begin
        if (abort)               w_next = IDLE;
        else if (w_hs && w_last) w_next = FINISH;
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Key/round datapath: load on start, step back on each non-final handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key   <= '0;
      r_round <= '0;
    end else if (r_state == IDLE && start) begin
      r_key   <= key_in;
      r_round <= 4'(NR);
    end else if (w_hs && !w_last) begin
      r_key   <= w_prev;
      r_round <= r_round - 4'd1;
    end
  end

  assign key_out   = r_key;
  assign key_round = r_round;
  assign key_valid = (r_state == EMIT);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FINISH);

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: stimulus pushes expected round keys,
// a negedge monitor pops and compares on every accepted handshake.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         reset, start, abort, key_ready;
  logic [127:0] key_in;
  logic         key_valid, busy, done;
  logic [127:0] key_out;
  logic [3:0]   key_round;

  inv_key_schedule #(.NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .abort(abort), .key_ready(key_ready), .key_valid(key_valid),
    .key_out(key_out), .key_round(key_round), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic         chk_key;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] akey [11];
  logic [127:0] zkey [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a1(input int lo);
    for (int r = 10; r >= lo; r--) sb.push_back('{4'(r), akey[r], 1'b1});
  endtask

  // Monitor: compare accepted keys against the scoreboard and check that
  // outputs hold still across stalled cycles.
  logic         prev_hold = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_rnd;
  always @(negedge clk) begin
    exp_t e;
    if (prev_hold && key_valid && !reset) begin
      chk("stall_key", key_out, prev_key);
      chk("stall_round", 128'(key_round), 128'(prev_rnd));
    end
    if (!reset && key_valid && key_ready && !abort) begin
      if (sb.size() == 0) begin
        chk("unexpected_handshake_round", 128'(key_round), 128'hx);
      end else begin
        e = sb.pop_front();
        chk("hs_round", 128'(key_round), 128'(e.rnd));
        if (e.chk_key) chk("hs_key", key_out, e.key);
      end
    end
    prev_hold = !reset && key_valid && !key_ready && !abort;
    prev_key  = key_out;
    prev_rnd  = key_round;
  end

  // Step until done has pulsed and dropped; leaves the bench in the IDLE cycle.
  task automatic run_seq(input logic rnd_ready, input int budget,
                         output int done_cyc, output int n_done);
    done_cyc = -1;
    n_done   = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end else if (n_done > 0) begin
        break;
      end
      if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
    end
    key_ready = 1'b1;
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (!(key_valid && key_round == r) && n < 50) begin
      tick();
      start = 1'b0;
      n++;
    end
    if (n >= 50) chk("wait_round_timeout", 128'(key_round), 128'(r));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, nd;
    logic saw_done;

    akey[0]  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    akey[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    akey[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    akey[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
    akey[4]  = 128'hef44a541_a8525b7f_b671253b_db0bad00;
    akey[5]  = 128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc;
    akey[6]  = 128'h6d88a37a_110b3efd_dbf98641_ca0093fd;
    akey[7]  = 128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f;
    akey[8]  = 128'head27321_b58dbad2_312bf560_7f8d292f;
    akey[9]  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    akey[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    // All-zero round-10 key stepped back by hand: rcon 36, 1b, 80.
    zkey[10] = 128'h0;
    zkey[9]  = 128'h55636363_00000000_00000000_00000000;
    zkey[8]  = 128'h2d000000_55636363_00000000_00000000;
    zkey[7]  = 128'hce636363_78636363_55636363_00000000;

    reset = 1'b1; start = 1'b0; abort = 1'b0; key_ready = 1'b1; key_in = '0;
    tick(); tick();
    chk("rst_valid", 128'(key_valid), 128'(0));
    chk("rst_key", key_out, 128'h0);
    chk("rst_round", 128'(key_round), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    reset = 1'b0;
    tick();

    // Abort while idle is a no-op.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", 128'(busy), 128'(0));
    chk("idle_abort_valid", 128'(key_valid), 128'(0));

    // FIPS-197 A.1 with ready held high: done on cycle 12.
    push_a1(0);
    key_in = akey[10]; start = 1'b1;
    run_seq(1'b0, 40, dc, nd);
    chk("a1_done_cycle", 128'(dc), 128'(12));
    chk("a1_done_pulses", 128'(nd), 128'(1));
    chk("a1_sb_empty", 128'(sb.size()), 128'(0));
    chk("a1_busy_after", 128'(busy), 128'(0));
    chk("a1_key_after", key_out, akey[0]);
    chk("a1_round_after", 128'(key_round), 128'(0));

    // Random backpressure.
    push_a1(0);
    key_in = akey[10]; start = 1'b1;
    run_seq(1'b1, 400, dc, nd);
    chk("bp_done_seen", 128'(dc > 0), 128'(1));
    chk("bp_sb_empty", 128'(sb.size()), 128'(0));

    // Abort at round 5 with ready high.
    push_a1(6);
    key_in = akey[10]; start = 1'b1;
    tick();
    start = 1'b0;
    wait_round(4'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 128'(key_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_round", 128'(key_round), 128'(5));
    chk("abort_key", key_out, akey[5]);
    chk("abort_sb_empty", 128'(sb.size()), 128'(0));
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 128'(saw_done), 128'(0));

    // Restart with start and abort together in IDLE: start wins.
    push_a1(0);
    key_in = akey[10]; start = 1'b1; abort = 1'b1;
    run_seq(1'b0, 40, dc, nd);
    chk("restart_done_cycle", 128'(dc), 128'(12));
    chk("restart_sb_empty", 128'(sb.size()), 128'(0));

    // Reset mid-sequence at round 3, with start held during reset.
    push_a1(4);
    key_in = akey[10]; start = 1'b1;
    tick();
    start = 1'b0;
    wait_round(4'd3);
    reset = 1'b1; start = 1'b1; key_in = '0;
    tick();
    chk("mrst_valid", 128'(key_valid), 128'(0));
    chk("mrst_key", key_out, 128'h0);
    chk("mrst_round", 128'(key_round), 128'(0));
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_done", 128'(done), 128'(0));
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    chk("mrst_start_ignored", 128'(busy), 128'(0));
    chk("mrst_sb_empty", 128'(sb.size()), 128'(0));

    // start pulsed mid-sequence with another key is ignored.
    push_a1(0);
    key_in = akey[10]; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    key_in = '0; start = 1'b1;
    run_seq(1'b0, 40, dc, nd);
    chk("midstart_done_seen", 128'(dc > 0), 128'(1));
    chk("midstart_sb_empty", 128'(sb.size()), 128'(0));
    chk("midstart_key0", key_out, akey[0]);

    // Back-to-back start in the cycle after done, all-zero round-10 key.
    for (int r = 10; r >= 0; r--) begin
      if (r >= 7) sb.push_back('{4'(r), zkey[r], 1'b1});
      else        sb.push_back('{4'(r), 128'h0, 1'b0});
    end
    key_in = '0; start = 1'b1;
    run_seq(1'b0, 40, dc, nd);
    chk("b2b_done_cycle", 128'(dc), 128'(12));
    chk("b2b_sb_empty", 128'(sb.size()), 128'(0));
    chk("b2b_round_after", 128'(key_round), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
